// File: rtl/businterface.sv
// CPU-side adapter onto the 32-bit big-endian bus: registers a longword address,
// lane strobes and lane-steered write data, and right-justifies bus read data.
module businterface (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic [1:0]  cpu_cycle_width,
  input  logic [31:0] cpu_data_out,
  output logic [31:0] cpu_data_in,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:2] businterface_address,
  input  logic [31:0] businterface_data_in,
  output logic [31:0] businterface_data_out,
  output logic [3:0]  businterface_data_strobes,
  output logic        businterface_bus_error,
  output logic        businterface_read,
  output logic        businterface_write
);

  localparam logic [1:0] CW_BYTE = 2'b00;
  localparam logic [1:0] CW_WORD = 2'b01;
  localparam logic [1:0] CW_LONG = 2'b10;

  logic [3:0]  lane_strobes;
  logic [31:0] steered_data;
  logic        misaligned;
  logic        request;
  logic        next_error;
  logic        next_read;
  logic        next_write;
  logic [3:0]  next_strobes;

  logic [1:0]  lane_q;
  logic [1:0]  width_q;

  // Steer write data into big-endian lanes; untouched lanes idle at all-ones.
  always_comb begin
    lane_strobes = 4'b0000;
    steered_data = 32'hffffffff;
    misaligned   = 1'b0;
    case (cpu_cycle_width)
      CW_BYTE: begin
        lane_strobes = 4'b1000 >> cpu_address[1:0];
        case (cpu_address[1:0])
          2'd0:    steered_data[31:24] = cpu_data_out[7:0];
          2'd1:    steered_data[23:16] = cpu_data_out[7:0];
          2'd2:    steered_data[15:8]  = cpu_data_out[7:0];
          default: steered_data[7:0]   = cpu_data_out[7:0];
        endcase
      end
      CW_WORD: begin
        misaligned = cpu_address[0];
        if (cpu_address[1]) begin
          lane_strobes       = 4'b0011;
          steered_data[15:0] = cpu_data_out[15:0];
        end else begin
          lane_strobes        = 4'b1100;
          steered_data[31:16] = cpu_data_out[15:0];
        end
      end
      CW_LONG: begin
        misaligned   = |cpu_address[1:0];
        lane_strobes = 4'b1111;
        steered_data = cpu_data_out;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // A simultaneous read and write resolves to a write; errors suppress the bus cycle.
  always_comb begin
    request      = cpu_read | cpu_write;
    next_error   = request & misaligned;
    next_write   = cpu_write & ~next_error;
    next_read    = cpu_read & ~cpu_write & ~next_error;
    next_strobes = (request && !next_error) ? lane_strobes : 4'b0000;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      businterface_address      <= '0;
      businterface_data_out     <= 32'hffffffff;
      businterface_data_strobes <= 4'b0000;
      businterface_read         <= 1'b0;
      businterface_write        <= 1'b0;
      businterface_bus_error    <= 1'b0;
      lane_q                    <= 2'b00;
      width_q                   <= CW_LONG;
    end else begin
      businterface_address      <= cpu_address[31:2];
      businterface_data_out     <= steered_data;
      businterface_data_strobes <= next_strobes;
      businterface_read         <= next_read;
      businterface_write        <= next_write;
      businterface_bus_error    <= next_error;
      lane_q                    <= cpu_address[1:0];
      width_q                   <= cpu_cycle_width;
    end
  end

  // Read path stays combinational so data is usable the cycle the bus returns it.
  always_comb begin
    cpu_data_in = 32'hffffffff;
    case (width_q)
      CW_BYTE: begin
        case (lane_q)
          2'd0:    cpu_data_in[7:0] = businterface_data_in[31:24];
          2'd1:    cpu_data_in[7:0] = businterface_data_in[23:16];
          2'd2:    cpu_data_in[7:0] = businterface_data_in[15:8];
          default: cpu_data_in[7:0] = businterface_data_in[7:0];
        endcase
      end
      CW_WORD: begin
        cpu_data_in[15:0] = lane_q[1] ? businterface_data_in[15:0]
                                      : businterface_data_in[31:16];
      end
      CW_LONG: begin
        cpu_data_in = businterface_data_in;
      end
      default: begin
        cpu_data_in = 32'hffffffff;
      end
    endcase
  end

endmodule

// File: tb/tb_businterface.sv
// Self-checking bench for businterface: directed cases plus randomized accesses
// compared against a shift/mask reference model.
module tb_businterface;

  logic        clock;
  logic        reset;
  logic [31:0] cpu_address;
  logic [1:0]  cpu_cycle_width;
  logic [31:0] cpu_data_out;
  logic [31:0] cpu_data_in;
  logic        cpu_read;
  logic        cpu_write;
  logic [29:0] businterface_address;
  logic [31:0] businterface_data_in;
  logic [31:0] businterface_data_out;
  logic [3:0]  businterface_data_strobes;
  logic        businterface_bus_error;
  logic        businterface_read;
  logic        businterface_write;

  int check_count = 0;
  int fail_count  = 0;

  businterface dut (
    .clock                     (clock),
    .reset                     (reset),
    .cpu_address               (cpu_address),
    .cpu_cycle_width           (cpu_cycle_width),
    .cpu_data_out              (cpu_data_out),
    .cpu_data_in               (cpu_data_in),
    .cpu_read                  (cpu_read),
    .cpu_write                 (cpu_write),
    .businterface_address      (businterface_address),
    .businterface_data_in      (businterface_data_in),
    .businterface_data_out     (businterface_data_out),
    .businterface_data_strobes (businterface_data_strobes),
    .businterface_bus_error    (businterface_bus_error),
    .businterface_read         (businterface_read),
    .businterface_write        (businterface_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
    end
  endtask

  function automatic bit model_misaligned(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'b01) return a[0];
    if (w == 2'b10) return a[1:0] != 2'b00;
    if (w == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_strobes(input logic [1:0] w, input logic [1:0] off);
    if (w == 2'b00) return 4'(1 << (3 - int'(off)));
    if (w == 2'b01) return (off == 2'd2) ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_write_data(input logic [1:0] w, input logic [1:0] off,
                                                   input logic [31:0] d);
    int sh;
    if (w == 2'b00) begin
      sh = 8 * (3 - int'(off));
      return ~(32'h000000ff << sh) | ({24'h0, d[7:0]} << sh);
    end
    if (w == 2'b01) begin
      sh = (off == 2'd2) ? 0 : 16;
      return ~(32'h0000ffff << sh) | ({16'h0, d[15:0]} << sh);
    end
    return d;
  endfunction

  function automatic logic [31:0] model_read_data(input logic [1:0] w, input logic [1:0] off,
                                                  input logic [31:0] bus);
    int sh;
    if (w == 2'b00) begin
      sh = 8 * (3 - int'(off));
      return 32'hffffff00 | ((bus >> sh) & 32'h000000ff);
    end
    if (w == 2'b01) begin
      sh = (off == 2'd2) ? 0 : 16;
      return 32'hffff0000 | ((bus >> sh) & 32'h0000ffff);
    end
    return bus;
  endfunction

  // Presents one access, lets it register, then checks request side and read path.
  task automatic applyStimulus(input logic [1:0] w, input logic [31:0] a, input logic rd,
                               input logic wr, input logic [31:0] wdata, input logic [31:0] bus);
    bit req, err;
    @(negedge clock);
    cpu_cycle_width = w;
    cpu_address     = a;
    cpu_read        = rd;
    cpu_write       = wr;
    cpu_data_out    = wdata;
    @(posedge clock);
    #1;
    req = rd | wr;
    err = req & model_misaligned(w, a);
    checkOutput("address", {2'b00, businterface_address}, {2'b00, a[31:2]});
    checkOutput("bus_error", {31'h0, businterface_bus_error}, {31'h0, err});
    checkOutput("write", {31'h0, businterface_write}, {31'h0, wr & ~err});
    checkOutput("read", {31'h0, businterface_read}, {31'h0, rd & ~wr & ~err});
    checkOutput("strobes", {28'h0, businterface_data_strobes},
                (req && !err) ? {28'h0, model_strobes(w, a[1:0])} : 32'h0);
    if (!model_misaligned(w, a)) begin
      checkOutput("data_out", businterface_data_out, model_write_data(w, a[1:0], wdata));
      businterface_data_in = bus;
      #1;
      checkOutput("data_in", cpu_data_in, model_read_data(w, a[1:0], bus));
    end
  endtask

  initial begin
    logic [1:0]  w;
    logic [31:0] a;
    reset                = 1'b1;
    cpu_address          = '0;
    cpu_cycle_width      = 2'b10;
    cpu_data_out         = '0;
    cpu_read             = 1'b0;
    cpu_write            = 1'b0;
    businterface_data_in = 32'h12345678;
    #2;
    checkOutput("reset_address", {2'b00, businterface_address}, 32'h0);
    checkOutput("reset_data_out", businterface_data_out, 32'hffffffff);
    checkOutput("reset_strobes", {28'h0, businterface_data_strobes}, 32'h0);
    checkOutput("reset_ctrl", {29'h0, businterface_read, businterface_write,
                               businterface_bus_error}, 32'h0);
    checkOutput("reset_data_in", cpu_data_in, 32'h12345678);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 32'h1000 + i, 1'b1, 1'b0, 32'h0, 32'h12345678);
      applyStimulus(2'b00, 32'h2000 + i, 1'b0, 1'b1, 32'h000000ab, 32'h12345678);
    end
    applyStimulus(2'b01, 32'h3000, 1'b1, 1'b0, 32'h0000abcd, 32'h12345678);
    applyStimulus(2'b01, 32'h3002, 1'b0, 1'b1, 32'h0000abcd, 32'h12345678);
    applyStimulus(2'b10, 32'h0, 1'b1, 1'b1, 32'habcdef12, 32'h12345678);
    applyStimulus(2'b01, 32'h3001, 1'b1, 1'b0, 32'h0, 32'h12345678);
    applyStimulus(2'b01, 32'h3003, 1'b0, 1'b1, 32'h0, 32'h12345678);
    for (int i = 1; i < 4; i++) applyStimulus(2'b10, 32'h4000 + i, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 32'h5000 + i, 1'b0, 1'b1, 32'h0, 32'h0);
    applyStimulus(2'b10, 32'h6001, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      w = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (w == 2'b01) a[0] = 1'b0;
        if (w == 2'b10) a[1:0] = 2'b00;
      end
      applyStimulus(w, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom);
    end

    applyStimulus(2'b00, 32'h7003, 1'b0, 1'b1, 32'h0000005a, 32'h12345678);
    #2;
    reset = 1'b1;
    businterface_data_in = 32'hcafef00d;
    #1;
    checkOutput("midreset_address", {2'b00, businterface_address}, 32'h0);
    checkOutput("midreset_data_out", businterface_data_out, 32'hffffffff);
    checkOutput("midreset_strobes", {28'h0, businterface_data_strobes}, 32'h0);
    checkOutput("midreset_ctrl", {29'h0, businterface_read, businterface_write,
                                  businterface_bus_error}, 32'h0);
    checkOutput("midreset_data_in", cpu_data_in, 32'hcafef00d);
    @(posedge clock);
    #1;
    checkOutput("held_reset_write", {31'h0, businterface_write}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(2'b10, 32'h00000010, 1'b1, 1'b0, 32'h0, 32'h89abcdef);
    checkOutput("post_reset_address", {2'b00, businterface_address}, 32'h4);
    checkOutput("post_reset_strobes", {28'h0, businterface_data_strobes}, 32'hf);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
